// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem req/ack, decode valid/ready, redirects
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   imem_req/addr/ack/rdata    instruction memory handshake (req held until ack)
//   instr_valid/instr_ready    decode handshake
//   instr, op, pc_out, pc_plus4  latched instruction, its opcode, its address and address+4
//   redirect, redirect_target  taken branch/jump from execute (target low bits ignored)
module fetch_unit #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [31:0]      instr,
    output logic [6:0]       op,
    output logic [XLEN-1:0]  pc_out,
    output logic [XLEN-1:0]  pc_plus4,
    input  logic             redirect,
    input  logic [XLEN-1:0]  redirect_target
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   pc_pending_q, pc_pending_d;
    logic [31:0]       instr_q, instr_d;
    logic [XLEN-1:0]   pc_out_q, pc_out_d;
    logic [XLEN-1:0]   target;

    // Targets are always word aligned; the low two bits from execute are dropped.
    assign target = redirect_target & ~XLEN'(3);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            pc_pending_q <= RESET_PC;
            instr_q      <= NOP;
            pc_out_q     <= RESET_PC;
        end else begin
            pc_q         <= pc_d;
            pc_pending_q <= pc_pending_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pc_pending_d = pc_pending_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                if (redirect) begin
                    pc_d = target;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        // Returned word belongs to the squashed path; refetch at target.
                        pc_d = target;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        state_d  = S_HOLD;
                    end
                end else if (redirect) begin
                    // Address must stay stable until the outstanding fetch completes.
                    pc_pending_d = target;
                    state_d      = S_DROP;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    pc_pending_d = target;
                end
                if (imem_ack) begin
                    pc_d    = redirect ? target : pc_pending_q;
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                // Redirect takes priority over a same-cycle accept.
                if (redirect) begin
                    pc_d    = target;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state_q)
            S_REQ, S_DROP: imem_req    = 1'b1;
            S_HOLD:        instr_valid = 1'b1;
            default: begin
                imem_req    = 1'b0;
                instr_valid = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign op        = instr_q[6:0];
    assign pc_out    = pc_out_q;
    assign pc_plus4  = pc_out_q + XLEN'(4);

endmodule
